prbs31_checker: RTL
===================

# prbs31_checker

Receive-side checker for the 31-bit PRBS word stream (polynomial x^31 + x^28 + 1; next word = {w[29:0], w[30]^w[27]}). It sits directly downstream of the PRBS generator, or of any link/FIFO that carries its words. It self-synchronises to the incoming stream, declares lock, and then counts bit errors against an internally advanced reference. Status and counters feed a register bank or debug ILA.

## Interface

Parameters:
- LOCK_COUNT, 16: consecutive matching words required to enter LOCKED (>=1).
- LOSS_COUNT, 4: consecutive erroneous words in LOCKED that force SEARCH (>=1).
- CNT_W, 32: width of err_cnt and word_cnt.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  31  received PRBS word.
- valid_in  in  1  data_in qualifier; words are consecutive PRBS states with no gaps in sequence.
- clear_in  in  1  synchronous clear of err_cnt, word_cnt, sticky_err.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle flag: the last valid word in LOCKED had >=1 bit error.
- err_bits  out  5  popcount of the error for that word (0..31).
- err_cnt  out  CNT_W  saturating total bit errors counted while LOCKED.
- word_cnt  out  CNT_W  saturating count of valid words checked while LOCKED.
- sticky_err  out  1  set on any error in LOCKED; cleared only by clear_in or reset.

## Operation

- States: SEARCH (reset state), LOCKED.
- Internal regs: ref[30:0], have_prev, match_cnt, miss_cnt.
- Cycles with valid_in=0: no state, counter, or register change; err_pulse=0.
- SEARCH, valid_in=1:
  - The first word after entering SEARCH only seeds: ref<=data_in, have_prev<=1, and no comparison is made.
  - Otherwise compare data_in with next(ref). On a match, match_cnt+1. On a mismatch, match_cnt<=0. In both cases ref<=data_in (reseed from the received word).
  - An all-zero data_in is always a mismatch, and it never becomes ref (ref and have_prev cleared), so the checker cannot lock onto the stuck state.
  - When the match makes match_cnt reach LOCK_COUNT: go to LOCKED, ref<=data_in, miss_cnt<=0.
  - No error counting in SEARCH.
- LOCKED, valid_in=1:
  - expected = next(ref); ref<=expected always. ref is never reseeded from data, so a corrupted word affects only itself.
  - e = popcount(data_in ^ expected); err_bits<=e; err_pulse<=(e!=0); word_cnt+1.
  - If e!=0: err_cnt += e (saturate at 2^CNT_W-1), sticky_err<=1, miss_cnt+1. Else miss_cnt<=0.
  - When miss_cnt reaches LOSS_COUNT: go to SEARCH, have_prev<=0, match_cnt<=0. The error counts for that word are still applied.
- clear_in=1 zeros err_cnt, word_cnt, sticky_err that cycle and takes priority over a same-cycle increment. FSM, ref, locked are unaffected.
- Counter arithmetic is CNT_W+1 wide and clamps to all-ones; no wrap.

## Timing

- All outputs are registered. Reset values: locked=0, err_pulse=0, err_bits=0, err_cnt=0, word_cnt=0, sticky_err=0. Internal: SEARCH, ref=0, have_prev=0, match_cnt=0, miss_cnt=0.
- Latency: the response to a valid word at edge N appears after edge N, i.e. it is visible during cycle N+1.
- Lock: with a clean stream, locked rises after the (LOCK_COUNT+1)-th valid word (1 seed + LOCK_COUNT matches).
- Loss: locked falls after the LOSS_COUNT-th consecutive errored word.
- err_pulse/err_bits reflect only the most recent valid cycle. err_pulse returns to 0 on the next clock edge regardless of valid_in; err_bits holds.
- Asynchronous reset assertion mid-stream immediately forces all reset values. After deassertion, relock requires a full seed + LOCK_COUNT sequence.
- Back-to-back valid_in every cycle is supported at full rate.

## Test plan

- Clean lock: reset, stream seeded with 2 (words 2, 4, 8, ...), valid every cycle -> locked=1 one cycle after the 17th valid word; err_cnt=0. After 100 more words, word_cnt=100.
- Single-bit error: while locked, send word with bit 0 flipped -> err_pulse for 1 cycle, err_bits=1, err_cnt=1, sticky_err=1, locked stays 1. The next correct word gives err_pulse=0, miss_cnt reset.
- Multi-bit/loss: 4 consecutive words each with 3 bits flipped -> err_cnt=12, locked=0 after the 4th. A following clean stream relocks after 17 words.
- Stuck-zero: all-zero data_in for 100 valid cycles -> locked never asserts. Gapped valid_in (every other cycle) on a clean stream -> lock after 17 valid words.
- Saturation and clear: CNT_W=4, inject a 31-bit-error word while locked -> err_cnt=15 (clamped). clear_in together with an errored word -> err_cnt=0, sticky_err=0, locked=1.
- Reset mid-lock: assert rst_n=0 while locked with err_cnt=5 -> all outputs reset immediately. Clean stream after release -> relock after 17 words.

Source files
------------

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises to the incoming
// word stream, declares lock, then counts bit errors against a free-running reference.
module prbs31_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [30:0]      data_in,
  input  logic             valid_in,
  input  logic             clear_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [4:0]       err_bits,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic             sticky_err,
  output logic             state_dbg
);

  localparam int MATCH_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
  // Wide enough to hold err_cnt plus a full 31-bit error even when CNT_W is small.
  localparam int SUM_W   = ((CNT_W > 5) ? CNT_W : 5) + 1;

  localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  LOSS_M  = MISS_W'(LOSS_COUNT);
  localparam logic [SUM_W-1:0]   CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [30:0]        ref_q;
  logic               have_prev;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  logic [30:0]        next_ref;
  logic [4:0]         err_now;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic [SUM_W-1:0]   err_sum;
  logic [CNT_W-1:0]   err_sat;
  logic [CNT_W-1:0]   word_sat;

  function automatic logic [4:0] popcount31(input logic [30:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 31; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    next_ref  = {ref_q[29:0], ref_q[30] ^ ref_q[27]};
    err_now   = popcount31(data_in ^ next_ref);
    match_inc = match_cnt + MATCH_W'(1);
    miss_inc  = miss_cnt + MISS_W'(1);
    err_sum   = SUM_W'(err_cnt) + SUM_W'(err_now);
    err_sat   = (err_sum > CNT_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    word_sat  = (&word_cnt) ? word_cnt : word_cnt + CNT_W'(1);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      ref_q      <= '0;
      have_prev  <= 1'b0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_bits   <= '0;
      err_cnt    <= '0;
      word_cnt   <= '0;
      sticky_err <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (valid_in) begin
        case (state)
          SEARCH: begin
            // All-zero is the LFSR lock-up state; never seed from it.
            if (data_in == '0) begin
              ref_q     <= '0;
              have_prev <= 1'b0;
              match_cnt <= '0;
            end else if (!have_prev) begin
              ref_q     <= data_in;
              have_prev <= 1'b1;
            end else begin
              ref_q <= data_in;
              if (data_in == next_ref) begin
                if (match_inc == LOCK_M) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  miss_cnt  <= '0;
                  match_cnt <= '0;
                end else begin
                  match_cnt <= match_inc;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            // Reference free-runs so a corrupted word only affects itself.
            ref_q     <= next_ref;
            err_bits  <= err_now;
            err_pulse <= (err_now != '0);
            word_cnt  <= word_sat;
            if (err_now != '0) begin
              err_cnt    <= err_sat;
              sticky_err <= 1'b1;
              if (miss_inc == LOSS_M) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                have_prev <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Clear wins over any same-cycle increment.
      if (clear_in) begin
        err_cnt    <= '0;
        word_cnt   <= '0;
        sticky_err <= 1'b0;
      end
    end
  end

endmodule
